// File: rtl/int_ctrl.sv
// int_ctrl -- interrupt sequencer for the 8-bit core.
//
// Purpose:
//     Sits directly upstream of the flag register. On interrupt entry the
//     return PC and the C/Z flags are saved and fetch is redirected to
//     VECTOR. On reti the saved PC is handed back to fetch and the saved
//     C/Z are written back into the flag register via iwe/intc_o/intz_o.
//     Single interrupt level, no nesting.
//
// Configuration macro:
//     INT_PENDING_LATCH_EN  - when defined, rising edges of int_req (on cen
//                             cycles) set a pending bit that is used as the
//                             take condition instead of the raw level, so
//                             short pulses between boundaries are not lost
//                             and requests arriving during an ISR are
//                             serviced after it returns.
//
// Parameters:
//     PC_W    program-counter width
//     VECTOR  ISR entry address driven on vector
//
// Ports:
//     clk        in   system clock
//     rst        in   synchronous, active-high reset
//     cen        in   clock enable; state advances only when 1
//     int_req    in   external interrupt request (level)
//     inst_done  in   instruction boundary this cycle
//     pc_next    in   address of next sequential instruction
//     c_flag     in   current carry
//     z_flag     in   current zero
//     reti       in   decoded reti, valid with inst_done
//     enai       in   decoded enable-interrupts, valid with inst_done
//     disi       in   decoded disable-interrupts, valid with inst_done
//     take_int   out  load PC with vector this cycle
//     vector     out  constant VECTOR
//     int_ack    out  acknowledge pulse to interrupt source
//     ret_valid  out  load PC with ret_pc this cycle
//     ret_pc     out  saved return address
//     iwe        out  flag-restore write enable
//     intc_o     out  saved carry (valid with iwe)
//     intz_o     out  saved zero (valid with iwe)
//     ie         out  interrupt-enable status
//     in_isr     out  high while entering, servicing or returning

module int_ctrl #(
    parameter int              PC_W   = 12,
    parameter logic [PC_W-1:0] VECTOR = 12'h001
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            int_req,
    input  logic            inst_done,
    input  logic [PC_W-1:0] pc_next,
    input  logic            c_flag,
    input  logic            z_flag,
    input  logic            reti,
    input  logic            enai,
    input  logic            disi,
    output logic            take_int,
    output logic [PC_W-1:0] vector,
    output logic            int_ack,
    output logic            ret_valid,
    output logic [PC_W-1:0] ret_pc,
    output logic            iwe,
    output logic            intc_o,
    output logic            intz_o,
    output logic            ie,
    output logic            in_isr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_ISR,
        ST_RETURN
    } state_e;

    state_e            state_q, state_d;
    logic              ie_q, ie_d;
    logic [PC_W-1:0]   savedPc_q, savedPc_d;
    logic              savedC_q, savedC_d;
    logic              savedZ_q, savedZ_d;
    logic              takeReq;

`ifdef INT_PENDING_LATCH_EN
    logic              pending_q, pending_d;
    logic              reqPrev_q, reqPrev_d;
    logic              riseEdge;

    // Edge detector and pending latch. An edge seen on the boundary cycle
    // itself counts immediately so a fresh request is not delayed a whole
    // instruction. The pending bit is consumed when the ENTER cycle retires.
    always_comb begin
        riseEdge  = int_req & ~reqPrev_q;
        reqPrev_d = reqPrev_q;
        pending_d = pending_q;
        if (cen) begin
            reqPrev_d = int_req;
            if (state_q == ST_ENTER) begin
                pending_d = 1'b0;
            end else if (riseEdge) begin
                pending_d = 1'b1;
            end
        end
        takeReq = pending_q | riseEdge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            reqPrev_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            reqPrev_q <= reqPrev_d;
        end
    end
`else
    // Plain level sampling: a request must be high on a boundary to be seen.
    always_comb begin
        takeReq = int_req;
    end
`endif

    // Next-state logic. Nothing moves on cycles with cen low. ie is the
    // registered value, so an enai on the same boundary as a request does
    // not admit that request; disi on the same boundary does block it.
    always_comb begin
        state_d   = state_q;
        ie_d      = ie_q;
        savedPc_d = savedPc_q;
        savedC_d  = savedC_q;
        savedZ_d  = savedZ_q;
        if (cen) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (inst_done && takeReq && ie_q && !disi) begin
                        savedPc_d = pc_next;
                        savedC_d  = c_flag;
                        savedZ_d  = z_flag;
                        state_d   = ST_ENTER;
                    end else if (inst_done) begin
                        if (disi) begin
                            ie_d = 1'b0;
                        end else if (enai) begin
                            ie_d = 1'b1;
                        end
                    end
                end
                ST_ENTER: begin
                    ie_d    = 1'b0;
                    state_d = ST_ISR;
                end
                ST_ISR: begin
                    if (inst_done && reti) begin
                        state_d = ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    ie_d    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ie_q      <= 1'b0;
            savedPc_q <= '0;
            savedC_q  <= 1'b0;
            savedZ_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            savedPc_q <= savedPc_d;
            savedC_q  <= savedC_d;
            savedZ_q  <= savedZ_d;
        end
    end

    // Pulses are gated by cen so a stalled ENTER/RETURN issues exactly one
    // effective load/write when the pipeline finally advances.
    assign take_int  = (state_q == ST_ENTER)  & cen;
    assign int_ack   = (state_q == ST_ENTER)  & cen;
    assign ret_valid = (state_q == ST_RETURN) & cen;
    assign iwe       = (state_q == ST_RETURN) & cen;
    assign vector    = VECTOR;
    assign ret_pc    = savedPc_q;
    assign intc_o    = savedC_q;
    assign intz_o    = savedZ_q;
    assign ie        = ie_q;
    assign in_isr    = (state_q != ST_IDLE);

endmodule
